// File: rtl/axi_lite_mem_port_pkg.sv
// Shared types for the AXI4-lite memory port: access sizes, fault codes,
// AXI response encodings and the port FSM state encoding.
package mem_port_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        BUS_ERR      = 2'b00,
        MISALIGNED   = 2'b01,
        ILLEGAL_SIZE = 2'b10,
        TIMEOUT      = 2'b11
    } fault_code_t;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B,
        ST_RESP
    } state_t;

    // Low address bits that must be zero for an access of this size.
    function automatic logic [2:0] size_mask(mem_size_t size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

    function automatic logic resp_is_err(logic [1:0] resp);
        return (resp == AXI_SLVERR) || (resp == AXI_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_mem_port_if.sv
// AXI4-lite bus bundle between the memory port (master) and the fabric (slave).
interface axi_lite_mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_mem_port_align.sv
// mem_lane_align: byte-lane steering for the memory port. Shifts store data
// and strobes up to the addressed lane, and pulls load data down from it with
// sign or zero extension. Purely combinational.
module mem_lane_align
    import mem_port_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mem_size_t                   size,
    input  logic                        is_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [DATA_W-1:0]           store_data,
    input  logic [DATA_W-1:0]           load_bus,
    output logic [DATA_W-1:0]           wdata,
    output logic [DATA_W/8-1:0]         wstrb,
    output logic [DATA_W-1:0]           load_data
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [NB-1:0]     strb_base;
    logic              sign;
    int                nbytes;

    // Build the access-size byte mask, then steer store and load data through it.
    always_comb begin
        nbytes    = 1 << size;
        mask      = '0;
        strb_base = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes) begin
                mask[8*i +: 8] = 8'hFF;
                strb_base[i]   = 1'b1;
            end
        end
        wdata   = store_data << {offset, 3'b000};
        wstrb   = strb_base << offset;
        shifted = load_bus >> {offset, 3'b000};
        case (size)
            SZ_BYTE: sign = shifted[7];
            SZ_HALF: sign = shifted[15];
            SZ_WORD: sign = shifted[31];
            default: sign = shifted[DATA_W-1];
        endcase
        load_data = shifted & mask;
        if (!is_unsigned && sign) begin
            load_data = load_data | ~mask;
        end
    end
endmodule

// File: rtl/axi_lite_mem_port.sv
// AXI4-lite master serving core fetches, loads and stores, one transaction
// at a time. Optional wait-state watchdog: define MEM_PORT_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a core request
// AR      | read address offered
// R       | waiting for read data
// AW_W    | write address and data offered, each retiring on its own
// B       | waiting for write response
// RESP    | response held for the core
module axi_lite_mem_port
    import mem_port_pkg::*;
#(
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 32,
    parameter logic [2:0] INSTR_PROT     = 3'b101,
    parameter logic [2:0] DATA_PROT      = 3'b000,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_instr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [1:0]        rsp_code,
    axi_lite_mem_port_if.master axi
);
    localparam int OFF = $clog2(DATA_W / 8);

    state_t              state_q, state_d;
    mem_size_t           size_in, size_q;
    logic                instr_q, unsigned_q, aw_done_q, w_done_q;
    logic [ADDR_W-1:0]   addr_q, addr_aligned;
    logic [DATA_W-1:0]   wdata_q, lane_wdata, lane_rdata;
    logic [DATA_W/8-1:0] lane_wstrb;
    logic                accept, illegal, misaligned, rd_done, wr_done, timeout_hit;
    logic                arvalid, rready, awvalid, wvalid, bready;

    assign size_in      = mem_size_t'(req_size);
    assign illegal      = (size_in == SZ_DWORD) && (DATA_W == 32);
    assign misaligned   = |(req_addr[2:0] & size_mask(size_in));
    assign req_ready    = (state_q == ST_IDLE) && reset;
    assign accept       = req_valid && req_ready;
    assign rd_done      = (state_q == ST_R) && axi.rvalid;
    assign wr_done      = (state_q == ST_B) && axi.bvalid;
    assign addr_aligned = addr_q & ~ADDR_W'(DATA_W / 8 - 1);

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             in_bus;

    assign in_bus = (state_q == ST_AR) || (state_q == ST_R) ||
                    (state_q == ST_AW_W) || (state_q == ST_B);

    // Down-counter armed on acceptance; terminal count ends the transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if (accept) begin
            tmo_cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (in_bus && tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    assign timeout_hit = in_bus && (tmo_cnt_q == '0) && !rd_done && !wr_done;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
    assign timeout_hit           = 1'b0;
`endif

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .offset      (addr_q[OFF-1:0]),
        .store_data  (wdata_q),
        .load_bus    (axi.rdata),
        .wdata       (lane_wdata),
        .wstrb       (lane_wstrb),
        .load_data   (lane_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal || misaligned) state_d = ST_RESP;
                    else if (req_write)        state_d = ST_AW_W;
                    else                       state_d = ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (timeout_hit)      state_d = ST_RESP;
                else if (axi.arready) state_d = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (axi.rvalid || timeout_hit) state_d = ST_RESP;
            end
            ST_AW_W: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (timeout_hit) begin
                    state_d = ST_RESP;
                end else if ((aw_done_q || axi.awready) && (w_done_q || axi.wready)) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                bready = 1'b1;
                if (axi.bvalid || timeout_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, write-channel bookkeeping and response capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            size_q     <= SZ_BYTE;
            instr_q    <= 1'b0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rsp_rdata  <= '0;
            rsp_fault  <= 1'b0;
            rsp_code   <= BUS_ERR;
        end else begin
            if (accept) begin
                size_q     <= size_in;
                instr_q    <= req_instr && !req_write;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                aw_done_q  <= 1'b0;
                w_done_q   <= 1'b0;
                if (illegal || misaligned) begin
                    rsp_rdata <= '0;
                    rsp_fault <= 1'b1;
                    rsp_code  <= illegal ? ILLEGAL_SIZE : MISALIGNED;
                end
            end
            if (state_q == ST_AW_W) begin
                if (axi.awready) aw_done_q <= 1'b1;
                if (axi.wready)  w_done_q  <= 1'b1;
            end
            if (timeout_hit) begin
                rsp_rdata <= '0;
                rsp_fault <= 1'b1;
                rsp_code  <= TIMEOUT;
            end else if (rd_done) begin
                rsp_rdata <= resp_is_err(axi.rresp) ? '0 : lane_rdata;
                rsp_fault <= resp_is_err(axi.rresp);
                rsp_code  <= BUS_ERR;
            end else if (wr_done) begin
                rsp_rdata <= '0;
                rsp_fault <= resp_is_err(axi.bresp);
                rsp_code  <= BUS_ERR;
            end
        end
    end

    // Address, data and prot are only driven while their channel is active.
    assign axi.arvalid = arvalid;
    assign axi.araddr  = arvalid ? addr_aligned : '0;
    assign axi.arprot  = arvalid ? (instr_q ? INSTR_PROT : DATA_PROT) : 3'b000;
    assign axi.rready  = rready;
    assign axi.awvalid = awvalid;
    assign axi.awaddr  = (state_q == ST_AW_W) ? addr_aligned : '0;
    assign axi.awprot  = (state_q == ST_AW_W) ? DATA_PROT : 3'b000;
    assign axi.wvalid  = wvalid;
    assign axi.wdata   = (state_q == ST_AW_W) ? lane_wdata : '0;
    assign axi.wstrb   = (state_q == ST_AW_W) ? lane_wstrb : '0;
    assign axi.bready  = bready;
endmodule
